// File: rtl/hazard_control_pkg.sv
// Shared ISA definitions and instruction-decode helpers for the hazard unit.
//   word_t           : 32-bit instruction word
//   OP_* / FN_*      : opcode and R-type funct encodings used by the hazard checks
//   hazard_e         : resolved hazard class, highest priority first in the top
//   decode helpers   : field extraction and the classification predicates
package hazard_control_pkg;

    localparam int unsigned WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        HZ_NONE,
        HZ_LOAD_USE,
        HZ_MD_INTERLOCK,
        HZ_BRANCH
    } hazard_e;

    function automatic logic [5:0] op_of(input word_t w);
        return w[31:26];
    endfunction

    function automatic logic [4:0] rs_of(input word_t w);
        return w[25:21];
    endfunction

    function automatic logic [4:0] rt_of(input word_t w);
        return w[20:16];
    endfunction

    function automatic logic [5:0] funct_of(input word_t w);
        return w[5:0];
    endfunction

    // Instruction starts a multi-cycle mult/div operation.
    function automatic logic is_muldiv(input word_t w);
        logic [5:0] fn;
        fn = funct_of(w);
        return (op_of(w) == OP_RTYPE) &&
               (fn == FN_MULT || fn == FN_MULTU || fn == FN_DIV || fn == FN_DIVU);
    endfunction

    // Instruction must wait for a pending HI/LO result (reads it, or would
    // overwrite it while the unit is still busy).
    function automatic logic needs_hilo(input word_t w);
        logic [5:0] fn;
        fn = funct_of(w);
        return (op_of(w) == OP_RTYPE) &&
               (fn == FN_MFHI || fn == FN_MFLO || fn == FN_MULT ||
                fn == FN_MULTU || fn == FN_DIV || fn == FN_DIVU);
    endfunction

    // Instruction reads the register named by its rt field.
    function automatic logic uses_rt(input word_t w);
        logic [5:0] op;
        op = op_of(w);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/hazard_control_if.sv
// Pipeline <-> hazard unit signal bundle.
//   master : pipeline side, drives the ID/EX words and branch resolution
//   slave  : hazard unit, returns PC/IF-ID enables, flushes, busy flag, stall count
interface hazard_control_if;
    import hazard_control_pkg::*;

    word_t       idInstruction;
    word_t       exInstruction;
    logic        exBranchTaken;
    logic        pcWrite;
    logic        ifIdWrite;
    logic        flushID;
    logic        flushEX;
    logic        mdBusy;
    logic [31:0] stallCount;

    modport master (
        output idInstruction, exInstruction, exBranchTaken,
        input  pcWrite, ifIdWrite, flushID, flushEX, mdBusy, stallCount
    );

    modport slave (
        input  idInstruction, exInstruction, exBranchTaken,
        output pcWrite, ifIdWrite, flushID, flushEX, mdBusy, stallCount
    );
endinterface

// File: rtl/hazard_control_muldiv_busy_counter.sv
// Countdown of cycles until the mult/div HI/LO result is available.
//   clk   : pipeline clock, state changes on the falling edge
//   reset : asynchronous, active-high, clears the counter
//   start : a mult/div is committed in EX this cycle; loads LOAD_VAL
//   count : remaining cycles
//   busy  : count != 0
module muldiv_busy_counter #(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned LOAD_VAL = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    // A load takes precedence over a decrement on the same edge.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= CNT_W'(LOAD_VAL);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard unit: issues flush/stall controls to IF/ID and ID/EX.
// Detects taken-branch redirects, HI/LO interlocks behind the mult/div unit
// and load-use hazards, and keeps a saturating count of stall cycles.
//   clk   : pipeline clock, all state changes on the falling edge
//   reset : asynchronous, active-high
//   bus   : hazard_control_if.slave (ID/EX words and branch in; controls out)
module hazard_control
    import hazard_control_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 8,
    parameter int unsigned CNT_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    hazard_control_if.slave  bus
);

    if (MULDIV_CYCLES < 1 || MULDIV_CYCLES >= (64'd1 << CNT_W)) begin : g_param_check
        $error("hazard_control: MULDIV_CYCLES must be in [1, 2**CNT_W)");
    end

    logic             md_start;
    logic [CNT_W-1:0] md_count;
    logic             md_busy;
    hazard_e          hazard;
    logic             pc_write;
    logic             if_id_write;
    logic             flush_id;
    logic             flush_ex;
    logic [31:0]      stall_cnt;

    // A mult/div being flushed by a taken branch never starts.
    assign md_start = is_muldiv(bus.exInstruction) && !bus.exBranchTaken;

    muldiv_busy_counter #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (MULDIV_CYCLES)
    ) u_md_counter (
        .clk   (clk),
        .reset (reset),
        .start (md_start),
        .count (md_count),
        .busy  (md_busy)
    );

    function automatic logic load_use(input word_t id_w, input word_t ex_w);
        logic [4:0] ex_rt;
        ex_rt = rt_of(ex_w);
        return (op_of(ex_w) == OP_LW) && (ex_rt != 5'd0) &&
               ((ex_rt == rs_of(id_w)) || (uses_rt(id_w) && ex_rt == rt_of(id_w)));
    endfunction

    // Reset masks every hazard so controls sit at their pass-through values.
    always_comb begin
        hazard = HZ_NONE;
        if (!reset) begin
            if (bus.exBranchTaken) begin
                hazard = HZ_BRANCH;
            end else if (md_count != '0 && needs_hilo(bus.idInstruction)) begin
                hazard = HZ_MD_INTERLOCK;
            end else if (load_use(bus.idInstruction, bus.exInstruction)) begin
                hazard = HZ_LOAD_USE;
            end
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        unique case (hazard)
            HZ_BRANCH: begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end
            HZ_MD_INTERLOCK, HZ_LOAD_USE: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                flush_ex    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (!pc_write && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.pcWrite    = pc_write;
    assign bus.ifIdWrite  = if_id_write;
    assign bus.flushID    = flush_id;
    assign bus.flushEX    = flush_ex;
    assign bus.mdBusy     = md_busy;
    assign bus.stallCount = stall_cnt;

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: table of combinational hazard
// vectors followed by directed multi-cycle sequences (mult/div interlock,
// flushed mult, reset mid-busy, stall counter saturation).
module tb_hazard_control;
    import hazard_control_pkg::*;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] LW8     = 32'h8D28_0000; // lw   $8,0($9)
    localparam logic [31:0] LW0     = 32'h8D20_0000; // lw   $0,0($9)
    localparam logic [31:0] ADD_RS8 = 32'h010B_5020; // add  $10,$8,$11
    localparam logic [31:0] ADD_RT8 = 32'h0128_5020; // add  $10,$9,$8
    localparam logic [31:0] ADD_RS0 = 32'h000B_5020; // add  $10,$0,$11
    localparam logic [31:0] SW8     = 32'hAD28_0004; // sw   $8,4($9)
    localparam logic [31:0] BEQ8    = 32'h1128_0000; // beq  $9,$8,0
    localparam logic [31:0] BNE8    = 32'h1528_0000; // bne  $9,$8,0
    localparam logic [31:0] ADDI8   = 32'h2128_0001; // addi $8,$9,1
    localparam logic [31:0] MULT    = 32'h012A_0018; // mult  $9,$10
    localparam logic [31:0] MULTU   = 32'h012A_0019; // multu $9,$10
    localparam logic [31:0] DIV     = 32'h012A_001A; // div   $9,$10
    localparam logic [31:0] MFLO    = 32'h0000_6012; // mflo $12
    localparam logic [31:0] MFHI    = 32'h0000_6010; // mfhi $12

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_control_if bus();

    hazard_control #(
        .MULDIV_CYCLES (8),
        .CNT_W         (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] exp_stall;

    typedef struct {
        string       name;
        logic [31:0] id;
        logic [31:0] ex;
        logic        br;
        logic        pc;
        logic        ifid;
        logic        fid;
        logic        fex;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, sample after the rising edge.
    task automatic cyc(input logic [31:0] id, input logic [31:0] ex, input logic br);
        @(negedge clk);
        #1;
        bus.idInstruction = id;
        bus.exInstruction = ex;
        bus.exBranchTaken = br;
        @(posedge clk);
        #1;
    endtask

    // Compares the controls plus stallCount; a stall cycle expected here is
    // counted (saturating) at the next falling edge.
    task automatic expect_ctl(input string name, input logic pc, input logic ifid,
                              input logic fid, input logic fex, input logic busy);
        check({name, ".pcWrite"},    32'(bus.pcWrite),   32'(pc));
        check({name, ".ifIdWrite"},  32'(bus.ifIdWrite), 32'(ifid));
        check({name, ".flushID"},    32'(bus.flushID),   32'(fid));
        check({name, ".flushEX"},    32'(bus.flushEX),   32'(fex));
        check({name, ".mdBusy"},     32'(bus.mdBusy),    32'(busy));
        check({name, ".stallCount"}, bus.stallCount,     exp_stall);
        if (!pc && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
    endtask

    task automatic add_vec(input string n, input logic [31:0] id, input logic [31:0] ex,
                           input logic br, input logic pc, input logic ifid,
                           input logic fid, input logic fex);
        vec_t v;
        v.name = n; v.id = id; v.ex = ex; v.br = br;
        v.pc = pc; v.ifid = ifid; v.fid = fid; v.fex = fex;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //             name          id       ex    br pc ifid fid fex
        add_vec("idle",        NOP,     NOP,  0, 1, 1, 0, 0);
        add_vec("lu_rs",       ADD_RS8, LW8,  0, 0, 0, 0, 1);
        add_vec("lu_rt_rtype", ADD_RT8, LW8,  0, 0, 0, 0, 1);
        add_vec("lu_rt_sw",    SW8,     LW8,  0, 0, 0, 0, 1);
        add_vec("lu_rt_beq",   BEQ8,    LW8,  0, 0, 0, 0, 1);
        add_vec("lu_rt_bne",   BNE8,    LW8,  0, 0, 0, 0, 1);
        add_vec("addi_rt",     ADDI8,   LW8,  0, 1, 1, 0, 0);
        add_vec("lw_rt",       LW8,     LW8,  0, 1, 1, 0, 0);
        add_vec("lw_r0",       ADD_RS0, LW0,  0, 1, 1, 0, 0);
        add_vec("ex_add",      ADD_RS8, ADD_RS8, 0, 1, 1, 0, 0);
        add_vec("ex_sw",       ADD_RS8, SW8,  0, 1, 1, 0, 0);
        add_vec("branch_pri",  ADD_RS8, LW8,  1, 1, 1, 1, 1);
        add_vec("mflo_idle",   MFLO,    NOP,  0, 1, 1, 0, 0);

        // Reset with a load-use pair present: controls must stay at defaults.
        exp_stall = 32'd0;
        reset = 1'b1;
        bus.idInstruction = ADD_RS8;
        bus.exInstruction = LW8;
        bus.exBranchTaken = 1'b0;
        #2;
        expect_ctl("reset", 1, 1, 0, 0, 0);
        @(negedge clk);
        #1;
        bus.idInstruction = NOP;
        bus.exInstruction = NOP;
        #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            cyc(vecs[i].id, vecs[i].ex, vecs[i].br);
            expect_ctl(vecs[i].name, vecs[i].pc, vecs[i].ifid, vecs[i].fid, vecs[i].fex, 1'b0);
        end

        // mult in EX, one independent instruction, then mflo held 7 cycles.
        cyc(NOP, MULT, 0);
        expect_ctl("md_issue", 1, 1, 0, 0, 0);
        cyc(NOP, NOP, 0);
        expect_ctl("md_gap", 1, 1, 0, 0, 1);
        for (int k = 0; k < 7; k++) begin
            cyc(MFLO, NOP, 0);
            expect_ctl($sformatf("md_hold%0d", k), 0, 0, 0, 1, 1);
        end
        cyc(MFLO, NOP, 0);
        expect_ctl("md_release", 1, 1, 0, 0, 0);

        // While busy: unrelated op passes, second div/mfhi held, branch wins.
        cyc(NOP, MULTU, 0);
        expect_ctl("md2_issue", 1, 1, 0, 0, 0);
        cyc(ADD_RS8, NOP, 0);
        expect_ctl("md2_add", 1, 1, 0, 0, 1);
        cyc(DIV, NOP, 0);
        expect_ctl("md2_div", 0, 0, 0, 1, 1);
        cyc(MFHI, NOP, 0);
        expect_ctl("md2_mfhi", 0, 0, 0, 1, 1);
        cyc(MFLO, NOP, 1);
        expect_ctl("md2_branch", 1, 1, 1, 1, 1);
        for (int i = 0; i < 20 && bus.mdBusy; i++) cyc(NOP, NOP, 0);
        check("md2_drain.mdBusy", 32'(bus.mdBusy), 32'd0);

        // A mult flushed by a taken branch never loads the counter.
        cyc(NOP, MULT, 1);
        expect_ctl("flushed_mult", 1, 1, 1, 1, 0);
        cyc(MFLO, NOP, 0);
        expect_ctl("flushed_after", 1, 1, 0, 0, 0);

        // Reset mid-busy: load 8, let it fall to 5, then assert reset.
        cyc(NOP, MULT, 0);
        expect_ctl("rst_issue", 1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(NOP, NOP, 0);
            expect_ctl($sformatf("rst_busy%0d", k), 1, 1, 0, 0, 1);
        end
        @(negedge clk);
        #1;
        bus.idInstruction = MFLO;
        #1;
        check("pre_reset.pcWrite", 32'(bus.pcWrite), 32'd0);
        bus.idInstruction = ADD_RS8;
        bus.exInstruction = LW8;
        reset = 1'b1;
        exp_stall = 32'd0;
        #1;
        expect_ctl("rst_mid", 1, 1, 0, 0, 0);
        @(negedge clk);
        #1;
        expect_ctl("rst_hold", 1, 1, 0, 0, 0);
        bus.idInstruction = NOP;
        bus.exInstruction = NOP;
        #1;
        reset = 1'b0;
        cyc(MFLO, NOP, 0);
        expect_ctl("rst_after", 1, 1, 0, 0, 0);

        // Saturation of the stall counter.
        @(negedge clk);
        #1;
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        exp_stall = 32'hFFFF_FFFE;
        cyc(ADD_RS8, LW8, 0);
        expect_ctl("sat0", 0, 0, 0, 1, 0);
        cyc(ADD_RS8, LW8, 0);
        expect_ctl("sat1", 0, 0, 0, 1, 0);
        cyc(NOP, NOP, 0);
        expect_ctl("sat2", 1, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
